datapath_core: RTL

//  Register/ALU datapath executing the control word from control_unit every cycle.

---
 rtl/datapath_core.sv | 131 +++++++++++++
 1 files changed

// File: rtl/datapath_core.sv
// datapath_core: register/ALU datapath (AR, PC, DR, IR, R, TR, AC, Z) with bus mux; DATAPATH_MULT_EN adds the MUL path.
// Loads land at the posedge (one-cycle latency); no backpressure, memory ports are combinational.
module datapath_core #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    write_en,
   input  logic [1:0]    inc,
   input  logic [3:0]    alu_mode,
   input  logic [2:0]    bus_ld,
   input  logic [2:0]    clr,
   input  logic          dm_wr,
   input  logic          end_op,
   input  logic [DW-1:0] im_rdata,
   input  logic [DW-1:0] dm_rdata,
   output logic [AW-1:0] im_addr,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   output logic          dm_we,
   output logic [7:0]    ir,
   output logic          z,
   output logic          done
);

   logic [AW-1:0] r_ar, r_pc;
   logic [DW-1:0] r_dr, r_r, r_tr, r_ac;
   logic [7:0]    r_ir;
   logic          r_z, r_done;

   logic [DW-1:0] w_bus, w_alu, w_ac_nxt;
   logic          w_ac_upd;

   always_comb begin
      w_bus = '0;
      case (bus_ld)
         3'd0:    w_bus = im_rdata;
         3'd1:    w_bus = dm_rdata;
         3'd2:    w_bus = DW'(r_pc);
         3'd3:    w_bus = r_dr;
         3'd4:    w_bus = r_r;
         3'd5:    w_bus = r_ac;
         3'd6:    w_bus = r_tr;
         default: w_bus = '0;
      endcase
   end

   always_comb begin
      w_alu = r_ac;
      case (alu_mode)
         4'b0000: w_alu = r_ac + w_bus;
         4'b0001: w_alu = r_ac - w_bus;
`ifdef DATAPATH_MULT_EN
         4'b0010: w_alu = r_ac * w_bus;
`endif
         4'b0101: w_alu = w_bus;
         default: w_alu = r_ac;
      endcase
   end

   // AC priority: clear, then bus/ALU load, then increment; z follows any AC update.
   always_comb begin
      w_ac_upd = clr[2] | write_en[0] | inc[1];
      w_ac_nxt = r_ac;
      if (clr[2])
         w_ac_nxt = '0;
      else if (write_en[0])
         w_ac_nxt = w_alu;
      else if (inc[1])
         w_ac_nxt = r_ac + DW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ar   <= '0;
         r_pc   <= '0;
         r_dr   <= '0;
         r_ir   <= '0;
         r_r    <= '0;
         r_tr   <= '0;
         r_ac   <= '0;
         r_z    <= 1'b1;
         r_done <= 1'b0;
      end else begin
         if (w_ac_upd) begin
            r_ac <= w_ac_nxt;
            r_z  <= (w_ac_nxt == '0);
         end

         if (clr[0])
            r_pc <= '0;
         else if (write_en[7] | write_en[5])
            r_pc <= w_bus[AW-1:0];
         else if (inc[0])
            r_pc <= r_pc + AW'(1);

         if (clr[0])
            r_ar <= '0;
         else if (write_en[7] | write_en[6])
            r_ar <= w_bus[AW-1:0];

         if (clr[0])
            r_r <= '0;
         else if (write_en[2])
            r_r <= w_bus;

         if (clr[1])
            r_tr <= '0;
         else if (write_en[1])
            r_tr <= w_bus;

         if (write_en[4])
            r_dr <= w_bus;
         if (write_en[3])
            r_ir <= w_bus[7:0];

         if (end_op)
            r_done <= 1'b1;
      end
   end

   assign im_addr  = r_pc;
   assign dm_addr  = r_ar;
   assign dm_wdata = w_bus;
   assign dm_we    = dm_wr;
   assign ir       = r_ir;
   assign z        = r_z;
   assign done     = r_done;

endmodule
